// File: rtl/core_design_pkg.sv
// core_design_pkg: shared state/mode types and luminosity weights for the grayscale engine
package core_design_pkg;
  typedef enum logic [2:0] {gs_idle, gs_run, gs_pause, gs_drain, gs_done, gs_abort} gs_states;
  typedef enum logic [1:0] {gs_avg = 2'd0, gs_lum = 2'd1, gs_light = 2'd2, gs_rsvd = 2'd3} gs_mode;
  localparam int gs_lum_r = 299;
  localparam int gs_lum_g = 587;
  localparam int gs_lum_b = 114;
  localparam int gs_lum_div = 1000;
endpackage

// File: rtl/grayscale_pixel_calc.sv
// grayscale_pixel_calc: one registered stage turning a packed {R,G,B} pixel into a gray value
module grayscale_pixel_calc
  import core_design_pkg::*;
#(
  parameter int CH_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3*CH_W-1:0] pix,
  input  gs_mode            mode,
  output logic [CH_W-1:0]   gray
);
  localparam int AW = CH_W + 2;
  localparam int LW = CH_W + 10;
  localparam int HW = CH_W + 1;
  logic [CH_W-1:0] r, g, b, mx, mn;
  logic [AW-1:0] avg;
  logic [LW-1:0] lum;
  logic [HW-1:0] lit;
  always_comb begin
    {r, g, b} = pix;
    mx = r > g ? (r > b ? r : b) : (g > b ? g : b);
    mn = r < g ? (r < b ? r : b) : (g < b ? g : b);
    avg = (AW'(r) + AW'(g) + AW'(b)) / AW'(3);
    lum = (LW'(gs_lum_r) * LW'(r) + LW'(gs_lum_g) * LW'(g) + LW'(gs_lum_b) * LW'(b)) / LW'(gs_lum_div);
    lit = (HW'(mx) + HW'(mn)) >> 1;
  end
  always_ff @(posedge clk) begin
    if (rst) gray <= '0;
    else gray <= mode == gs_avg ? CH_W'(avg) : mode == gs_lum ? CH_W'(lum) : mode == gs_light ? CH_W'(lit) : '0;
  end
endmodule

// File: rtl/grayscale_stream_engine.sv
// grayscale_stream_engine: streams a pixel block through the gray calculator into destination memory
module grayscale_stream_engine
  import core_design_pkg::*;
#(
  parameter int CH_W       = 8,
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic [1:0]        cfg_mode,
  input  logic [ADDR_W-1:0] cfg_src_base,
  input  logic [ADDR_W-1:0] cfg_dst_base,
  input  logic [CNT_W-1:0]  cfg_num_pix,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [3*CH_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CH_W-1:0]   wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  pix_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  gs_states state;
  gs_mode mode;
  logic [ADDR_W-1:0] src_base, dst_base;
  logic [CNT_W-1:0] num_pix, issued, written, inflight;
  logic v1, v2, pop, last;
  logic [CH_W-1:0] gray;
  logic [CH_W-1:0] mem [FIFO_DEPTH];
  logic [PW:0] wp, rp;
  grayscale_pixel_calc #(.CH_W(CH_W)) u_calc (
    .clk (clk),
    .rst (rst),
    .pix (rd_data),
    .mode(mode),
    .gray(gray)
  );
  always_comb begin
    busy = state == gs_run || state == gs_pause || state == gs_drain;
    done = state == gs_done;
    aborted = state == gs_abort;
    wr_en = busy && wp != rp;
    pop = wr_en && wr_ready;
    last = pop && written == num_pix - 1'b1;
    inflight = issued - written - CNT_W'(pop);
    rd_req = state == gs_run && !pause && issued < num_pix && inflight < CNT_W'(FIFO_DEPTH);
    rd_addr = src_base + ADDR_W'(issued);
    wr_addr = dst_base + ADDR_W'(written);
    wr_data = wr_en ? mem[rp[PW-1:0]] : '0;
    pix_count = written;
  end
  always_ff @(posedge clk) begin
    if (v2) mem[wp[PW-1:0]] <= gray;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= gs_idle;
      mode <= gs_avg;
      src_base <= '0;
      dst_base <= '0;
      num_pix <= '0;
      issued <= '0;
      written <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      wp <= '0;
      rp <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      v1 <= rd_req;
      v2 <= v1;
      if (rd_req) issued <= issued + 1'b1;
      if (v2) wp <= wp + 1'b1;
      if (pop) begin
        rp <= rp + 1'b1;
        written <= written + 1'b1;
      end
      case (state)
        gs_idle: if (start) begin
          if (cfg_mode == 2'd3) cfg_err <= 1'b1;
          else if (cfg_num_pix == '0) state <= gs_done;
          else begin
            mode <= gs_mode'(cfg_mode);
            src_base <= cfg_src_base;
            dst_base <= cfg_dst_base;
            num_pix <= cfg_num_pix;
            issued <= '0;
            written <= '0;
            state <= gs_run;
          end
        end
        gs_run, gs_pause, gs_drain: begin
          // completion outranks abort; abort flushes the pipeline and FIFO
          if (last) state <= gs_done;
          else if (abort) begin
            state <= gs_abort;
            v1 <= 1'b0;
            v2 <= 1'b0;
            wp <= '0;
            rp <= '0;
          end else if (state == gs_run) state <= issued == num_pix ? gs_drain : pause ? gs_pause : gs_run;
          else if (state == gs_pause && !pause) state <= gs_run;
        end
        default: state <= gs_idle;
      endcase
    end
  end
endmodule

// File: tb/tb_grayscale_stream_engine.sv
// tb_grayscale_stream_engine: directed self-checking bench for the grayscale stream engine
module tb_grayscale_stream_engine;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [1:0] cfg_mode = '0;
  logic [15:0] cfg_src_base = '0, cfg_dst_base = '0, cfg_num_pix = '0;
  logic rd_req, wr_en, busy, done, aborted, cfg_err;
  logic [15:0] rd_addr, wr_addr, pix_count;
  logic [23:0] rd_data = '0;
  logic [7:0] wr_data;
  logic wr_ready = 1'b1;
  logic [23:0] src_mem [0:65535];
  logic [15:0] cap_addr [0:127];
  logic [7:0] cap_data [0:127];
  int tests = 0, fails = 0, cyc = 0;
  int rd_cnt, ncap, done_cnt, ab_cnt, err_cnt, pause_rd_err, stab_err, max_inf, first_rd, first_wr, last_wr;
  logic hold_v, req_q;
  logic [15:0] hold_a, addr_q;
  logic [7:0] hold_d;
  int exp1 [3] = '{116, 124, 125};
  int errs;
  grayscale_stream_engine dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .cfg_mode(cfg_mode), .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .cfg_num_pix(cfg_num_pix),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done), .aborted(aborted), .cfg_err(cfg_err), .pix_count(pix_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    rd_data <= req_q ? src_mem[addr_q] : '0;
  end
  always @(negedge clk) begin
    if (rd_req) begin
      if (first_rd < 0) first_rd = cyc;
      rd_cnt++;
      if (pause) pause_rd_err++;
    end
    if (wr_en && first_wr < 0) first_wr = cyc;
    if (wr_en && wr_ready && ncap < 128) begin
      cap_addr[ncap] = wr_addr;
      cap_data[ncap] = wr_data;
      ncap++;
      last_wr = cyc;
    end
    if (hold_v && (!wr_en || wr_addr !== hold_a || wr_data !== hold_d)) stab_err++;
    hold_v = wr_en && !wr_ready;
    hold_a = wr_addr;
    hold_d = wr_data;
    if (rd_cnt - ncap > max_inf) max_inf = rd_cnt - ncap;
    done_cnt += int'(done);
    ab_cnt += int'(aborted);
    err_cnt += int'(cfg_err);
    req_q = rd_req;
    addr_q = rd_addr;
  end
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    rd_cnt = 0; ncap = 0; done_cnt = 0; ab_cnt = 0; err_cnt = 0; pause_rd_err = 0;
    stab_err = 0; max_inf = 0; first_rd = -1; first_wr = -1; last_wr = -1; hold_v = 1'b0;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start_job(input logic [1:0] m, input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    cfg_mode = m; cfg_src_base = s; cfg_dst_base = d; cfg_num_pix = n;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask
  task automatic wait_end(input int budget);
    for (int i = 0; i < budget && done_cnt == 0 && ab_cnt == 0; i++) cycle();
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) src_mem[i] = '0;
    src_mem[16'h0010] = {8'd200, 8'd100, 8'd50};
    for (int i = 0; i < 64; i++) src_mem[16'h0200 + i] = (i % 2 == 0) ? 24'hFFFFFF : 24'h000000;
    for (int i = 0; i < 16; i++) src_mem[16'h0300 + i] = {8'(10 * i), 8'(5 * i), 8'(i)};
    for (int i = 0; i < 20; i++) src_mem[16'h0500 + i] = {3{8'(7 * i + 3)}};
    clr();
    repeat (3) cycle();
    check("reset_outputs", {rd_req, wr_en, busy, done, aborted, cfg_err, pix_count, rd_addr, wr_addr, wr_data}, 64'd0);
    rst = 1'b0;
    cycle();
    for (int m = 0; m < 3; m++) begin
      clr();
      start_job(2'(m), 16'h0010, 16'h0100, 16'd1);
      wait_end(50);
      check("t1_done", 64'(done_cnt), 64'd1);
      check("t1_nwrites", 64'(ncap), 64'd1);
      check("t1_addr", 64'(cap_addr[0]), 64'h0100);
      check("t1_data", 64'(cap_data[0]), 64'(exp1[m]));
      check("t1_pix_count", 64'(pix_count), 64'd1);
    end
    clr();
    start_job(2'd0, 16'h0200, 16'h0400, 16'd64);
    wait_end(300);
    errs = 0;
    for (int i = 0; i < 64; i++)
      if (cap_addr[i] !== 16'(16'h0400 + i) || cap_data[i] !== ((i % 2 == 0) ? 8'd255 : 8'd0)) errs++;
    check("t2_done", 64'(done_cnt), 64'd1);
    check("t2_nwrites", 64'(ncap), 64'd64);
    check("t2_latency", 64'(first_wr - first_rd), 64'd3);
    check("t2_back_to_back", 64'(last_wr - first_wr), 64'd63);
    check("t2_data", 64'(errs), 64'd0);
    check("t2_pix_count", 64'(pix_count), 64'd64);
    clr();
    wr_ready = 1'b0;
    start_job(2'd2, 16'h0300, 16'h0800, 16'd16);
    cfg_mode = 2'd0;
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      wr_ready = (k % 4 == 3);
      cycle();
    end
    wr_ready = 1'b1;
    errs = 0;
    for (int i = 0; i < 16; i++)
      if (cap_addr[i] !== 16'(16'h0800 + i) || cap_data[i] !== 8'((11 * i) / 2)) errs++;
    check("t3_done", 64'(done_cnt), 64'd1);
    check("t3_nwrites", 64'(ncap), 64'd16);
    check("t3_inflight_max", 64'(max_inf <= 4), 64'd1);
    check("t3_stable", 64'(stab_err), 64'd0);
    check("t3_order_data", 64'(errs), 64'd0);
    clr();
    start_job(2'd1, 16'h0500, 16'h0900, 16'd20);
    for (int k = 0; k < 50 && rd_cnt < 5; k++) cycle();
    pause = 1'b1;
    repeat (10) cycle();
    check("t4_paused_reads", 64'(rd_cnt), 64'd5);
    check("t4_paused_drained", 64'(ncap), 64'd5);
    check("t4_busy_in_pause", 64'(busy), 64'd1);
    pause = 1'b0;
    wait_end(200);
    errs = 0;
    for (int i = 0; i < 20; i++)
      if (cap_addr[i] !== 16'(16'h0900 + i) || cap_data[i] !== 8'(7 * i + 3)) errs++;
    check("t4_done", 64'(done_cnt), 64'd1);
    check("t4_nwrites", 64'(ncap), 64'd20);
    check("t4_data", 64'(errs), 64'd0);
    check("t4_no_rd_in_pause", 64'(pause_rd_err), 64'd0);
    clr();
    start_job(2'd0, 16'h0600, 16'h0a00, 16'd20);
    for (int k = 0; k < 100 && ncap < 7; k++) cycle();
    abort = 1'b1;
    wr_ready = 1'b0;
    cycle();
    abort = 1'b0;
    check("t5_abort_cycle", {wr_en, rd_req, aborted, busy}, 64'b0010);
    wr_ready = 1'b1;
    cycle();
    check("t5_idle", {busy, aborted, wr_en, rd_req}, 64'd0);
    check("t5_pix_count", 64'(pix_count), 64'd7);
    repeat (5) cycle();
    check("t5_nwrites", 64'(ncap), 64'd7);
    check("t5_abort_pulses", 64'(ab_cnt), 64'd1);
    check("t5_no_done", 64'(done_cnt), 64'd0);
    clr();
    start_job(2'd1, 16'h0010, 16'h0100, 16'd1);
    wait_end(50);
    check("t5_restart_data", {ncap[7:0], cap_addr[0], cap_data[0]}, {8'd1, 16'h0100, 8'd124});
    check("t5_restart_count", 64'(pix_count), 64'd1);
    clr();
    start_job(2'd3, 16'h0010, 16'h0100, 16'd5);
    check("t6_cfg_err", {cfg_err, busy}, 64'b10);
    cycle();
    check("t6_cfg_err_pulse", {cfg_err, busy}, 64'b00);
    start_job(2'd0, 16'h0010, 16'h0100, 16'd0);
    check("t6_zero_done", {done, busy, rd_req}, 64'b100);
    cycle();
    check("t6_zero_idle", {done, busy}, 64'b00);
    check("t6_no_reads", 64'(rd_cnt + ncap), 64'd0);
    check("t6_err_pulses", 64'(err_cnt), 64'd1);
    clr();
    start_job(2'd0, 16'h0200, 16'h0c00, 16'd40);
    for (int k = 0; k < 100 && ncap < 3; k++) cycle();
    rst = 1'b1;
    cycle();
    check("t7_rst_outputs", {rd_req, wr_en, busy, done, aborted, cfg_err, pix_count, rd_addr, wr_addr, wr_data}, 64'd0);
    rst = 1'b0;
    clr();
    repeat (10) cycle();
    check("t7_quiet_after_rst", 64'(rd_cnt + ncap + done_cnt + ab_cnt), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
